// File: rtl/adder_accum_pkg.sv
// Shared types and constants for the byte-serial multi-cycle adder/accumulator tile.
package adder_accum_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_A = 2'b00,
        OP_LOAD_B = 2'b01,
        OP_EXEC   = 2'b10,
        OP_READ   = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        M_ADD = 2'b00,
        M_SUB = 2'b01,
        M_ACC = 2'b10,
        M_CLR = 2'b11
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int STROBE  = 0;
    localparam int OPC_LSB = 1;
    localparam int BUSY    = 4;
    localparam int CARRY   = 5;
    localparam int OVF     = 6;
    localparam int DONE    = 7;

    localparam logic [7:0] UIO_OE = 8'hF0;

    // Counter width that stays legal when the count range collapses to one value.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_accum_adder_slice.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB.
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/tt_um_adder_accum.sv
// Byte-serial loader, multi-cycle chunked adder/accumulator with flags,
// byte-serial readback and idle auto-clear.
module tt_um_adder_accum
    import adder_accum_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CHUNK       = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int N  = WIDTH / CHUNK;
    localparam int NB = WIDTH / 8;
    localparam int IW = cw(N);
    localparam int RW = cw(NB);
    localparam int HW = cw(HOLD_CYCLES + 1);

    state_e             state;
    logic [2:0]         sync;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   r_reg;
    logic [WIDTH-1:0]   wa;
    logic [WIDTH-1:0]   wb;
    logic [WIDTH-1:0]   wsum;
    logic [IW-1:0]      idx;
    logic               cy;
    logic               carry_f;
    logic               ovf_f;
    logic               done;
    logic [RW-1:0]      rd_ptr;
    logic [HW-1:0]      hold_cnt;

    logic               accept;
    logic               last;
    opcode_e            opc;
    mode_e              mode;
    logic [CHUNK-1:0]   s_sum;
    logic               s_cout;
    logic               s_cmsb;
    logic [WIDTH-1:0]   r_next;
    logic               unused_ok;

    assign accept = sync[1] & ~sync[2] & ena & (state == S_IDLE);
    assign opc    = opcode_e'(uio_in[OPC_LSB +: 2]);
    assign mode   = mode_e'(ui_in[1:0]);
    assign last   = (idx == IW'(N - 1));

    adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (wa[idx*CHUNK +: CHUNK]),
        .b     (wb[idx*CHUNK +: CHUNK]),
        .cin   (cy),
        .sum   (s_sum),
        .cout  (s_cout),
        .c_msb (s_cmsb)
    );

    // Final result merges the last slice, so R updates in the same edge as the flags.
    always_comb begin
        r_next = wsum;
        r_next[idx*CHUNK +: CHUNK] = s_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sync     <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            r_reg    <= '0;
            wa       <= '0;
            wb       <= '0;
            wsum     <= '0;
            idx      <= '0;
            cy       <= 1'b0;
            carry_f  <= 1'b0;
            ovf_f    <= 1'b0;
            done     <= 1'b0;
            rd_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            sync <= {sync[1:0], uio_in[STROBE]};
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        hold_cnt <= '0;
                        unique case (opc)
                            OP_LOAD_A: a_reg <= WIDTH'({a_reg, ui_in});
                            OP_LOAD_B: b_reg <= WIDTH'({b_reg, ui_in});
                            OP_READ: begin
                                if (rd_ptr == RW'(NB - 1))
                                    rd_ptr <= '0;
                                else
                                    rd_ptr <= rd_ptr + 1'b1;
                            end
                            OP_EXEC: begin
                                if (mode == M_CLR) begin
                                    r_reg   <= '0;
                                    carry_f <= 1'b0;
                                    ovf_f   <= 1'b0;
                                    done    <= 1'b1;
                                end else begin
                                    wa     <= (mode == M_ACC) ? r_reg : a_reg;
                                    wb     <= (mode == M_ADD) ? b_reg :
                                              (mode == M_SUB) ? ~b_reg : a_reg;
                                    cy     <= (mode == M_SUB);
                                    wsum   <= '0;
                                    idx    <= '0;
                                    done   <= 1'b0;
                                    rd_ptr <= '0;
                                    state  <= S_RUN;
                                end
                            end
                        endcase
                    end else if (done && HOLD_CYCLES != 0) begin
                        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                            hold_cnt <= '0;
                            r_reg    <= '0;
                            carry_f  <= 1'b0;
                            ovf_f    <= 1'b0;
                            done     <= 1'b0;
                            rd_ptr   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    cy   <= s_cout;
                    idx  <= idx + 1'b1;
                    wsum[idx*CHUNK +: CHUNK] <= s_sum;
                    if (last) begin
                        idx      <= '0;
                        r_reg    <= r_next;
                        carry_f  <= s_cout;
                        ovf_f    <= s_cmsb ^ s_cout;
                        done     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        uio_out        = '0;
        uio_out[BUSY]  = (state == S_RUN);
        uio_out[CARRY] = carry_f;
        uio_out[OVF]   = ovf_f;
        uio_out[DONE]  = done;
    end

    assign uo_out    = r_reg[8*rd_ptr +: 8];
    assign uio_oe    = UIO_OE;
    assign unused_ok = &{1'b0, uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_adder_accum.sv
// Scoreboard bench for tt_um_adder_accum (WIDTH=16, CHUNK=4, HOLD_CYCLES=20).
module tb_tt_um_adder_accum;

    localparam int W = 16;
    localparam int C = 4;
    localparam int H = 20;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int t_done = 0;

    logic [15:0] ma = '0;
    logic [15:0] mb = '0;
    logic [15:0] mr = '0;
    exp_t sbq[$];

    tt_um_adder_accum #(.WIDTH(W), .CHUNK(C), .HOLD_CYCLES(H)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] m);
        exp_t e;
        logic [16:0] s;
        logic [15:0] x;
        logic [15:0] y;
        x = (m == 2'd2) ? mr : ma;
        y = (m == 2'd0) ? mb : (m == 2'd1) ? ~mb : ma;
        s = {1'b0, x} + {1'b0, y} + {16'd0, (m == 2'd1)};
        e.r = s[15:0];
        e.c = s[16];
        e.v = (x[15] == y[15]) && (s[15] != x[15]);
        return e;
    endfunction

    task automatic cmd(input logic [1:0] opc, input logic [7:0] d);
        @(negedge clk);
        ui_in  = d;
        uio_in = {5'b0, opc, 1'b1};
        repeat (4) @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        if (ena && opc == 2'b00) ma = {ma[7:0], d};
        if (ena && opc == 2'b01) mb = {mb[7:0], d};
    endtask

    task automatic load16(input logic [1:0] opc, input logic [15:0] v);
        cmd(opc, v[15:8]);
        cmd(opc, v[7:0]);
    endtask

    task automatic exec(input logic [1:0] m, input bit poke, input bit rd);
        int   bc;
        bit   got;
        exp_t e;
        sbq.push_back(model(m));
        bc  = 0;
        got = 0;
        @(negedge clk);
        ui_in  = {6'b0, m};
        uio_in = {5'b0, 2'b10, 1'b1};
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) uio_in[0] = 1'b0;
            if (i == 2 && poke) begin
                ui_in  = 8'hFF;
                uio_in = {5'b0, 2'b00, 1'b1};
            end
            if (uio_out[4]) begin
                bc++;
            end else if (bc > 0) begin
                got    = 1;
                t_done = cyc;
                check("done_after_busy", {31'd0, uio_out[7]}, 32'd1);
                break;
            end
        end
        uio_in[0] = 1'b0;
        check("exec_complete", {31'd0, got}, 32'd1);
        check("busy_cycles", bc, 32'd4);
        repeat (3) @(negedge clk);
        if (sbq.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check("r_lo", {24'd0, uo_out}, {24'd0, e.r[7:0]});
            check("carry", {31'd0, uio_out[5]}, {31'd0, e.c});
            check("ovf", {31'd0, uio_out[6]}, {31'd0, e.v});
            mr = e.r;
            if (rd) begin
                cmd(2'b11, 8'h00);
                check("r_hi", {24'd0, uo_out}, {24'd0, e.r[15:8]});
                cmd(2'b11, 8'h00);
                check("r_wrap", {24'd0, uo_out}, {24'd0, e.r[7:0]});
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_uo_out", {24'd0, uo_out}, 32'h00);
        check("rst_uio_out", {24'd0, uio_out}, 32'h00);
        check("rst_uio_oe", {24'd0, uio_oe}, 32'hF0);
        rst_n = 1'b1;
        @(negedge clk);

        load16(2'b00, 16'h1234);
        load16(2'b01, 16'h0FF0);
        exec(2'd0, 0, 1);

        load16(2'b00, 16'h0001);
        load16(2'b01, 16'h0002);
        exec(2'd1, 0, 1);
        load16(2'b00, 16'h8000);
        load16(2'b01, 16'h0001);
        exec(2'd1, 0, 1);

        load16(2'b00, 16'h7FFF);
        exec(2'd0, 0, 1);
        load16(2'b00, 16'hFFFF);
        exec(2'd0, 0, 1);

        ena = 1'b0;
        cmd(2'b00, 8'hAA);
        ena = 1'b1;
        load16(2'b01, 16'h0002);
        exec(2'd0, 0, 1);

        cmd(2'b10, 8'h03);
        mr = '0;
        check("clr_done", {31'd0, uio_out[7]}, 32'd1);
        check("clr_r", {24'd0, uo_out}, 32'h00);
        check("clr_flags", {30'd0, uio_out[6:5]}, 32'd0);
        load16(2'b00, 16'h0100);
        exec(2'd2, 0, 0);
        exec(2'd2, 1, 0);
        exec(2'd2, 0, 1);
        check("acc_total", {16'd0, mr}, 32'h0300);

        load16(2'b00, 16'h1234);
        load16(2'b01, 16'h1111);
        exec(2'd0, 0, 0);
        @(negedge clk);
        ui_in  = 8'h00;
        uio_in = {5'b0, 2'b10, 1'b1};
        @(posedge clk);
        #1 uio_in[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[4]) break;
        end
        check("run_busy", {31'd0, uio_out[4]}, 32'd1);
        check("run_r_held", {24'd0, uo_out}, 32'h45);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_uo_out", {24'd0, uo_out}, 32'h00);
        check("mid_rst_uio_out", {24'd0, uio_out}, 32'h00);
        check("mid_rst_uio_oe", {24'd0, uio_oe}, 32'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        ma = '0;
        mb = '0;
        mr = '0;
        repeat (3) @(negedge clk);
        exec(2'd0, 0, 1);

        load16(2'b00, 16'h0003);
        load16(2'b01, 16'h0004);
        exec(2'd0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (!uio_out[7]) break;
        end
        check("hold_elapsed", cyc - t_done, 32'd20);
        check("hold_r", {24'd0, uo_out}, 32'h00);
        check("hold_done", {31'd0, uio_out[7]}, 32'd0);
        mr = '0;

        exec(2'd0, 0, 0);
        for (int i = 0; i < 40 && (cyc - t_done) < 12; i++) begin
            @(posedge clk);
            #1;
        end
        ui_in  = 8'h00;
        uio_in = {5'b0, 2'b11, 1'b1};
        @(posedge clk);
        #1 uio_in[0] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (!uio_out[7]) break;
        end
        check("hold_restart", cyc - t_done, 32'd35);
        check("hold2_r", {24'd0, uo_out}, 32'h00);
        check("hold2_flags", {29'd0, uio_out[7:5]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
